// File: rtl/adex_step_scheduler_if.sv
// rtl/adex_step_scheduler_if.sv - datapath issue/response bus and AER spike stream of the AdEx step scheduler
interface adex_step_scheduler_if #(
    parameter int N  = 23,
    parameter int NE = 38,
    parameter int AW = 4
);
    logic          dp_valid;
    logic [N-1:0]  dp_V;
    logic [N-1:0]  dp_VP;
    logic [N-1:0]  dp_W;
    logic [N-1:0]  dp_I;
    logic [NE-1:0] dp_exp;
    logic          dp_rvalid;
    logic [N-1:0]  dp_V_n;
    logic [N-1:0]  dp_VP_n;
    logic [N-1:0]  dp_W_n;
    logic [NE-1:0] dp_exp_n;
    logic          dp_spike;
    logic          aer_valid;
    logic          aer_ready;
    logic [AW-1:0] aer_addr;

    modport master (
        output dp_valid, dp_V, dp_VP, dp_W, dp_I, dp_exp,
        input  dp_rvalid, dp_V_n, dp_VP_n, dp_W_n, dp_exp_n, dp_spike,
        output aer_valid, aer_addr,
        input  aer_ready
    );

    modport slave (
        input  dp_valid, dp_V, dp_VP, dp_W, dp_I, dp_exp,
        output dp_rvalid, dp_V_n, dp_VP_n, dp_W_n, dp_exp_n, dp_spike,
        input  aer_valid, aer_addr,
        output aer_ready
    );
endinterface

// File: rtl/adex_step_scheduler.sv
// rtl/adex_step_scheduler.sv - time-multiplexes one AdEx datapath over NUM_NEURONS neurons, AER spike FIFO
// Optional refractory skipping is enabled by defining ADEX_SCHED_REFRACT_EN.
module adex_step_scheduler #(
    parameter int            NUM_NEURONS = 16,
    parameter int            AW          = $clog2(NUM_NEURONS),
    parameter int            N           = 23,
    parameter int            NE          = 38,
    parameter logic [N-1:0]  EL          = 23'h7E_DED3,
    parameter logic [N-1:0]  W_INIT      = 23'h00_7803,
    parameter logic [NE-1:0] EXP_INIT    = 38'h0_0000_002B,
    parameter int            FIFO_DEPTH  = 8
`ifdef ADEX_SCHED_REFRACT_EN
    , parameter int          REFRACT_STEPS = 2
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    output logic          busy,
    output logic          step_done,
    output logic          tick_overrun,
    output logic [AW-1:0] cur_idx,
    input  logic [N-1:0]  cur_I,
    output logic          aer_overflow,
    output logic [15:0]   step_count,
    adex_step_scheduler_if.master bus
);
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} state_t;
    state_t state, state_nx;

    logic [N-1:0]  v_mem   [NUM_NEURONS];
    logic [N-1:0]  vp_mem  [NUM_NEURONS];
    logic [N-1:0]  w_mem   [NUM_NEURONS];
    logic [NE-1:0] exp_mem [NUM_NEURONS];

    logic [AW-1:0] idx;
    logic [N-1:0]  dp_v_q, dp_vp_q, dp_w_q, dp_i_q;
    logic [NE-1:0] dp_exp_q;

    logic last, wb, skip, advance, push;

    assign last    = (idx == AW'(NUM_NEURONS - 1));
    assign wb      = (state == S_WAIT) && bus.dp_rvalid;
    assign advance = wb || skip;
    assign push    = wb && bus.dp_spike;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != S_IDLE);
        step_done = advance && last && !rst;
        case (state)
            S_IDLE:  if (tick) state_nx = S_LOAD;
            S_LOAD:  state_nx = skip ? (last ? S_IDLE : S_LOAD) : S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (bus.dp_rvalid) state_nx = last ? S_IDLE : S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i]   <= EL;
                vp_mem[i]  <= EL;
                w_mem[i]   <= W_INIT;
                exp_mem[i] <= EXP_INIT;
            end
            idx          <= '0;
            dp_v_q       <= '0;
            dp_vp_q      <= '0;
            dp_w_q       <= '0;
            dp_i_q       <= '0;
            dp_exp_q     <= '0;
            step_count   <= '0;
            tick_overrun <= 1'b0;
        end else begin
            if (tick && state != S_IDLE) tick_overrun <= 1'b1;
            if (tick && state == S_IDLE) idx <= '0;
            // operands stay frozen from here until the response is written back
            if (state == S_LOAD && !skip) begin
                dp_v_q   <= v_mem[idx];
                dp_vp_q  <= vp_mem[idx];
                dp_w_q   <= w_mem[idx];
                dp_exp_q <= exp_mem[idx];
                dp_i_q   <= cur_I;
            end
            if (wb) begin
                v_mem[idx]   <= bus.dp_V_n;
                vp_mem[idx]  <= bus.dp_VP_n;
                w_mem[idx]   <= bus.dp_W_n;
                exp_mem[idx] <= bus.dp_exp_n;
            end
            if (skip) begin
                v_mem[idx]   <= EL;
                vp_mem[idx]  <= EL;
                exp_mem[idx] <= EXP_INIT;
            end
            if (advance) begin
                if (last) step_count <= step_count + 16'd1;
                else      idx <= idx + 1'b1;
            end
        end
    end

`ifdef ADEX_SCHED_REFRACT_EN
    localparam int RW = $clog2(REFRACT_STEPS + 1);
    logic [RW-1:0] refr [NUM_NEURONS];

    assign skip = (state == S_LOAD) && (refr[idx] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) refr[i] <= '0;
        end else if (skip) begin
            refr[idx] <= refr[idx] - 1'b1;
        end else if (push) begin
            refr[idx] <= RW'(REFRACT_STEPS);
        end
    end
`else
    assign skip = 1'b0;
`endif

    assign cur_idx      = idx;
    assign bus.dp_valid = (state == S_ISSUE);
    assign bus.dp_V     = dp_v_q;
    assign bus.dp_VP    = dp_vp_q;
    assign bus.dp_W     = dp_w_q;
    assign bus.dp_I     = dp_i_q;
    assign bus.dp_exp   = dp_exp_q;

    logic [AW-1:0] fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0]   count;
    logic          full, pop, push_ok;

    assign full          = (count == (FW+1)'(FIFO_DEPTH));
    assign bus.aer_valid = (count != '0);
    assign bus.aer_addr  = fifo_mem[rd_ptr];
    assign pop           = bus.aer_valid && bus.aer_ready;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push_ok       = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            aer_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push && !push_ok) aer_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adex_step_scheduler.sv
// tb/tb_adex_step_scheduler.sv - self-checking bench for adex_step_scheduler with a stub datapath
module tb_adex_step_scheduler;
    localparam int NN = 16, AW = 4, N = 23, NE = 38, DEPTH = 8;
    localparam logic [N-1:0]  EL       = 23'h7E_DED3;
    localparam logic [N-1:0]  W_INIT   = 23'h00_7803;
    localparam logic [NE-1:0] EXP_INIT = 38'h0_0000_002B;

    logic          clk = 1'b0;
    logic          rst, tick, busy, step_done, tick_overrun, aer_overflow;
    logic [AW-1:0] cur_idx;
    logic [N-1:0]  cur_I;
    logic [15:0]   step_count;

    adex_step_scheduler_if #(.N(N), .NE(NE), .AW(AW)) bus ();

    adex_step_scheduler #(.NUM_NEURONS(NN)) dut (
        .clk(clk), .rst(rst), .tick(tick), .busy(busy), .step_done(step_done),
        .tick_overrun(tick_overrun), .cur_idx(cur_idx), .cur_I(cur_I),
        .aer_overflow(aer_overflow), .step_count(step_count), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int issue_cnt = 0, pop_cnt = 0, done_cnt = 0, mdl_steps = 0;
    logic [15:0]   fire_mask = '0;
    logic [15:0]   issued_mask = '0;
    logic          stray_req = 1'b0, ignore_rsp = 1'b0, mdl_ovf = 1'b0;
    logic [AW-1:0] rsp_idx = '0;
    logic [AW-1:0] exp_issue [$];
    logic [AW-1:0] mdl_q [$];
    logic [N-1:0]  mdl_v [NN];
    logic [N-1:0]  mdl_vp [NN];
    logic [N-1:0]  mdl_w [NN];
    logic [NE-1:0] mdl_exp [NN];
    int            mdl_ref [NN];
    bit            m_pop, m_push, m_full;

    function automatic logic [N-1:0] cur_i_of(logic [AW-1:0] k);
        return N'(k) * 23'd4099 + 23'd17;
    endfunction

    assign cur_I = cur_i_of(cur_idx);

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Stub datapath: one-cycle latency, deterministic next-state, spike resets V/VP/exp.
    initial begin : stub
        int e;
        logic f;
        bus.dp_rvalid = 1'b0; bus.dp_spike = 1'b0;
        bus.dp_V_n = '0; bus.dp_VP_n = '0; bus.dp_W_n = '0; bus.dp_exp_n = '0;
        forever begin
            @(negedge clk);
            if (stray_req) begin
                ignore_rsp = 1'b1;
                @(posedge clk); #1;
                bus.dp_rvalid = 1'b1; bus.dp_spike = 1'b1;
                @(posedge clk); #1;
                bus.dp_rvalid = 1'b0; bus.dp_spike = 1'b0; ignore_rsp = 1'b0;
            end else if (bus.dp_valid && !rst) begin
                issue_cnt++;
                check("issue_expected", exp_issue.size() != 0, 1'b1);
                e = (exp_issue.size() != 0) ? int'(exp_issue.pop_front()) : 0;
                issued_mask[e] = 1'b1;
                check("issue_idx", cur_idx, e);
                check("dp_V", bus.dp_V, mdl_v[e]);
                check("dp_VP", bus.dp_VP, mdl_vp[e]);
                check("dp_W", bus.dp_W, mdl_w[e]);
                check("dp_exp", bus.dp_exp, mdl_exp[e]);
                check("dp_I", bus.dp_I, cur_i_of(AW'(e)));
                f = fire_mask[e];
                @(posedge clk); #1;
                rsp_idx = AW'(e);
                bus.dp_spike = f;
                if (f) begin
                    bus.dp_V_n = EL; bus.dp_VP_n = EL;
                    bus.dp_W_n = mdl_w[e] + 23'h100; bus.dp_exp_n = EXP_INIT;
                end else begin
                    bus.dp_V_n = mdl_v[e] + N'(e + 1); bus.dp_VP_n = mdl_v[e];
                    bus.dp_W_n = mdl_w[e] ^ 23'h5; bus.dp_exp_n = mdl_exp[e] + NE'(e + 1);
                end
                bus.dp_rvalid = 1'b1;
                @(negedge clk);
                if (!rst) begin
                    mdl_v[e] = bus.dp_V_n; mdl_vp[e] = bus.dp_VP_n;
                    mdl_w[e] = bus.dp_W_n; mdl_exp[e] = bus.dp_exp_n;
                    if (f) mdl_ref[e] = 2;
                end
                @(posedge clk); #1;
                bus.dp_rvalid = 1'b0; bus.dp_spike = 1'b0;
            end
        end
    end

    // AER scoreboard: spikes queue on writeback, compared as they leave the FIFO.
    always @(negedge clk) begin
        if (!rst) begin
            check("aer_valid", bus.aer_valid, mdl_q.size() != 0);
            if (mdl_q.size() != 0) check("aer_addr", bus.aer_addr, mdl_q[0]);
            check("aer_overflow", aer_overflow, mdl_ovf);
            m_full = (mdl_q.size() == DEPTH);
            m_pop  = (mdl_q.size() != 0) && bus.aer_ready;
            m_push = bus.dp_rvalid && bus.dp_spike && !ignore_rsp;
            if (m_pop) begin
                void'(mdl_q.pop_front());
                pop_cnt++;
            end
            if (m_push) begin
                if (!m_full || m_pop) mdl_q.push_back(rsp_idx);
                else mdl_ovf = 1'b1;
            end
            if (step_done) done_cnt++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < NN; i++) begin
            mdl_v[i] = EL; mdl_vp[i] = EL; mdl_w[i] = W_INIT; mdl_exp[i] = EXP_INIT; mdl_ref[i] = 0;
        end
        mdl_q.delete(); exp_issue.delete();
        mdl_ovf = 1'b0; mdl_steps = 0;
        rst = 1'b0;
    endtask

    task automatic build_list(output int exp_lat, output int n_iss);
        int skp = 0;
        n_iss = 0;
        exp_issue.delete();
        issued_mask = '0;
        for (int i = 0; i < NN; i++) begin
`ifdef ADEX_SCHED_REFRACT_EN
            if (mdl_ref[i] != 0) begin
                mdl_ref[i]--;
                mdl_v[i] = EL; mdl_vp[i] = EL; mdl_exp[i] = EXP_INIT;
                skp++;
                continue;
            end
`endif
            exp_issue.push_back(AW'(i));
            n_iss++;
        end
        exp_lat = 3 * n_iss + skp;
    endtask

    // Pulses tick (called at posedge+1) and returns cycles until step_done, -1 on timeout.
    task automatic run_step(input int ovr_at, output int lat);
        int c = 0;
        bit seen = 0;
        tick = 1'b1;
        while (!seen && c < 400) begin
            @(negedge clk);
            if (step_done) seen = 1;
            else begin
                @(posedge clk); #1;
                c++;
                tick = (c == ovr_at);
            end
        end
        tick = 1'b0;
        lat = seen ? c : -1;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int c = 0;
        bus.aer_ready = 1'b1;
        while ((mdl_q.size() != 0 || bus.aer_valid) && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_empty", bus.aer_valid, 1'b0);
    endtask

    typedef struct {
        logic [15:0] fire;
        logic        ready;
        int          exp_pops;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int lat, elat, n_iss, p0, ic0, d0, c;
        vecs[0] = '{16'h0000, 1'b1, 0, 1'b0};
        vecs[1] = '{16'h0088, 1'b1, 2, 1'b0};
        vecs[2] = '{16'hFFFF, 1'b0, 8, 1'b1};
        vecs[3] = '{16'hA5A5, 1'b1, 8, 1'b1};

        tick = 1'b0;
        bus.aer_ready = 1'b0;
        do_reset();

        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_step_done", step_done, 1'b0);
        check("rst_tick_overrun", tick_overrun, 1'b0);
        check("rst_step_count", step_count, 16'd0);
        check("rst_dp_valid", bus.dp_valid, 1'b0);
        check("rst_dp_V", bus.dp_V, '0);
        check("rst_dp_exp", bus.dp_exp, '0);
        check("rst_cur_idx", cur_idx, '0);
        @(posedge clk); #1;

        stray_req = 1'b1;
        @(posedge clk); #1;
        stray_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("stray_busy", busy, 1'b0);
        check("stray_step_count", step_count, 16'd0);
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            fire_mask = vecs[v].fire;
            bus.aer_ready = vecs[v].ready;
            p0 = pop_cnt;
            ic0 = issue_cnt;
            build_list(elat, n_iss);
            run_step(-1, lat);
            check("step_latency", lat, elat);
            check("issue_count", issue_cnt - ic0, n_iss);
            mdl_steps++;
            check("step_count", step_count, mdl_steps);
            check("idle_after_step", busy, 1'b0);
            drain();
`ifndef ADEX_SCHED_REFRACT_EN
            check("aer_pops", pop_cnt - p0, vecs[v].exp_pops);
`endif
            check("overflow_flag", aer_overflow, vecs[v].exp_ovf);
        end

        fire_mask = '0;
        ic0 = issue_cnt;
        build_list(elat, n_iss);
        run_step(10, lat);
        check("ovr_latency", lat, elat);
        check("ovr_flag", tick_overrun, 1'b1);
        mdl_steps++;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        check("ovr_no_restart", busy, 1'b0);
        check("ovr_issue_count", issue_cnt - ic0, n_iss);
        check("ovr_step_count", step_count, mdl_steps);
        @(posedge clk); #1;

        do_reset();
        fire_mask = '0;
        ic0 = issue_cnt;
        build_list(elat, n_iss);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        c = 0;
        while (issue_cnt - ic0 < 6 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_neuron5", issue_cnt - ic0, 6);
        d0 = done_cnt;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_step_count", step_count, 16'd0);
        check("abort_overrun_clear", tick_overrun, 1'b0);
        @(posedge clk); #1;
        build_list(elat, n_iss);
        run_step(-1, lat);
        check("restart_latency", lat, 48);
        check("restart_step_count", step_count, 16'd1);

`ifdef ADEX_SCHED_REFRACT_EN
        do_reset();
        for (int s = 0; s < 4; s++) begin
            fire_mask = (s == 0) ? 16'h0004 : 16'h0000;
            build_list(elat, n_iss);
            run_step(-1, lat);
            check("refr_latency", lat, elat);
            check("refr_n2_issued", issued_mask[2], (s == 0 || s == 3));
            drain();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adex_step_scheduler.md
# adex_step_scheduler

Time-multiplexing controller that shares one AdEx neuron update datapath among `NUM_NEURONS` virtual neurons. On each `tick` it walks every neuron in index order. For each one it reads the neuron's state from an internal register file, issues it to the external update datapath, waits for the result and writes it back. Spikes from the datapath are queued as neuron addresses in an AER output FIFO for the synapse/routing stage.

## Interface
- `NUM_NEURONS`, 16: virtual neurons; ≥2.
- `AW`, `$clog2(NUM_NEURONS)`: neuron address width.
- `N`, 23: width of V, VP, W (signed Q3.20).
- `NE`, 38: width of exp (signed Q18.20).
- `EL`, `23'shF_EDED_3`: reset/post-spike value of V and VP.
- `W_INIT`, `23'sh0_0780_3`: reset value of W.
- `EXP_INIT`, `38'sh0_0000_0002_B`: reset/post-spike value of exp.
- `FIFO_DEPTH`, 8: AER FIFO entries; power of two.
- `REFRACT_STEPS`, 2: refractory length in ticks (only with `ADEX_SCHED_REFRACT_EN`).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: start one time step; single-cycle pulse.
- `busy` out 1: a step is in progress.
- `step_done` out 1: one-cycle pulse after the last writeback of a step.
- `tick_overrun` out 1: sticky; set by a `tick` while `busy`.
- `cur_idx` out AW: neuron index whose input current is sampled.
- `cur_I` in N: input current for `cur_idx`, combinational from the stimulus source.
- `dp_valid` out 1: issue strobe, one cycle.
- `dp_V`, `dp_VP`, `dp_W` out N, and `dp_exp` out NE: operand state, held stable from issue until response.
- `dp_I` out N: registered `cur_I`.
- `dp_rvalid` in 1: datapath result valid.
- `dp_V_n`, `dp_VP_n`, `dp_W_n` in N, and `dp_exp_n` in NE: next state.
- `dp_spike` in 1: neuron fired this step; qualified by `dp_rvalid`.
- `aer_valid` out 1, `aer_ready` in 1, `aer_addr` out AW: spike address stream.
- `aer_overflow` out 1: sticky; set when a spike is dropped.
- `step_count` out 16: completed-step counter.

## Operation
- Reset: all neurons V=VP=EL, W=W_INIT, exp=EXP_INIT. FSM goes to IDLE. All outputs 0 (`dp_*` operands 0). FIFO is emptied. `step_count`=0. Sticky flags clear. Reset mid-step aborts the step with no writeback and no `step_done`.
- FSM has four states:
  - IDLE: `tick` → LOAD with idx=0. Otherwise stay.
  - LOAD: register the state of neuron idx and `cur_I` (with `cur_idx`=idx) → ISSUE.
  - ISSUE: assert `dp_valid` for one cycle → WAIT.
  - WAIT: on `dp_rvalid`, write `dp_*_n` into neuron idx and push idx into the FIFO if `dp_spike`. If idx=NUM_NEURONS-1, pulse `step_done`, increment `step_count` (wraps at 0xFFFF→0) and go to IDLE. Otherwise idx++ and go to LOAD.
- `dp_rvalid` outside WAIT is ignored.
- Only one neuron is in flight at a time.
- `busy`=1 in every state except IDLE.
- `tick` outside IDLE sets `tick_overrun` and is otherwise ignored.
- State values are stored bit-exact. The scheduler performs no arithmetic on neuron state.
- AER FIFO:
  - `aer_valid` = not empty; `aer_addr` = head entry.
  - Pop on `aer_valid && aer_ready`.
  - Push while full with no simultaneous pop: drop the spike and set `aer_overflow`.
  - Push and pop in the same cycle while full: both succeed.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- `cur_idx` is valid in the LOAD cycle.
- `dp_valid` rises 2 cycles after `tick` for neuron 0.
- Response-to-next-issue latency is 2 cycles (writeback/LOAD, then ISSUE).
- With a 1-cycle datapath, per-neuron cost is 3 cycles. A step takes 3·NUM_NEURONS cycles from `tick` to `step_done`.
- A FIFO push in cycle t makes `aer_valid` high at t+1.
- `tick` is accepted again in the cycle after `step_done`, since the FSM is then in IDLE.

## Configuration
- `ADEX_SCHED_REFRACT_EN` defined:
  - Each neuron has a refractory counter; it loads `REFRACT_STEPS` on a spike writeback.
  - In LOAD, a neuron with counter≠0 is not issued. Its counter decrements, its state stays at post-spike values (V=VP=EL, exp=EXP_INIT, W from the last writeback), and the FSM advances directly to the next idx (or completes the step).
  - Reset clears all counters.
- Undefined: no counters are present, and every neuron is issued every step.

## Test plan
- Reset then `tick`, with a stub datapath returning its inputs and `dp_spike`=0 → 16 `dp_valid` pulses, `dp_V`=EL each, `step_done` 48 cycles after `tick`, `step_count`=1, FIFO empty.
- Stub fires neurons 3 and 7, `aer_ready`=1 → `aer_addr` 3 then 7, one cycle each, `aer_overflow`=0.
- `aer_ready`=0, all 16 neurons fire, FIFO_DEPTH=8 → 8 entries held, `aer_overflow`=1, draining yields addresses 0–7.
- `tick` pulsed mid-step → `tick_overrun`=1, the step completes normally, and no second step starts.
- `rst` asserted during neuron 5 WAIT → V=EL for all neurons, `busy`=0, no `step_done`; the next `tick` restarts at idx 0.
- With `ADEX_SCHED_REFRACT_EN` and REFRACT_STEPS=2, neuron 2 fires in step 0 → neuron 2 is not issued in steps 1–2 and is issued again in step 3.
